// File: rtl/aes_word_loader_if.sv
// Word-stream and aes_core-facing signal bundle for aes_word_loader.
// slave = the loader itself; master = the upstream word source plus the core side.
interface aes_word_loader_if;
    logic [31:0]  word_in;
    logic         word_valid_in;
    logic         word_is_key_in;
    logic         en_or_de_in;
    logic         word_ready_out;
    logic [127:0] key_out;
    logic [127:0] text_out;
    logic         en_or_de_out;
    logic         start_out;
    logic         core_done_in;
    logic         busy_out;
    logic         done_out;
    logic         timeout_out;

    modport slave (
        input  word_in, word_valid_in, word_is_key_in, en_or_de_in, core_done_in,
        output word_ready_out, key_out, text_out, en_or_de_out, start_out,
               busy_out, done_out, timeout_out
    );

    modport master (
        output word_in, word_valid_in, word_is_key_in, en_or_de_in, core_done_in,
        input  word_ready_out, key_out, text_out, en_or_de_out, start_out,
               busy_out, done_out, timeout_out
    );
endinterface

// File: rtl/aes_word_loader.sv
// Assembles 32-bit key/text words into 128-bit blocks for aes_core, fires a
// one-cycle start, then waits for the core's done flag or a timeout.
module aes_word_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              reset,
    aes_word_loader_if.slave  bus
);
    localparam int unsigned           TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {LOAD, FIRE, WAIT} state_t;

    state_t             state_reg, state_next;
    logic [127:0]       key_reg, text_reg;
    logic [1:0]         key_cnt_reg, text_cnt_reg;
    logic               key_loaded_reg, text_full_reg;
    logic               en_or_de_reg, done_reg;
    logic [TIMER_W-1:0] timer_reg;

    logic word_ready, accept, key_accept, text_accept;
    logic key_loaded_next, text_full_next;
    logic core_done, timer_expired;
    logic start, busy, timeout;

    // Extra text words stall while a full text block waits for its key.
    always_comb begin
        word_ready      = (state_reg == LOAD) && !reset
                          && !(text_full_reg && !bus.word_is_key_in);
        accept          = bus.word_valid_in && word_ready;
        key_accept      = accept && bus.word_is_key_in;
        text_accept     = accept && !bus.word_is_key_in;
        key_loaded_next = key_loaded_reg;
        text_full_next  = text_full_reg;
        if (key_accept)
            key_loaded_next = (key_cnt_reg == 2'd3);
        if (text_accept)
            text_full_next = (text_cnt_reg == 2'd3);
        core_done     = (state_reg == WAIT) && bus.core_done_in;
        timer_expired = (state_reg == WAIT) && (timer_reg == TIMER_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= LOAD;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        busy       = 1'b0;
        timeout    = 1'b0;
        case (state_reg)
            LOAD: begin
                if (accept && key_loaded_next && text_full_next)
                    state_next = FIRE;
            end
            FIRE: begin
                start      = 1'b1;
                busy       = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                // A done arriving on the last timer cycle takes priority.
                timeout = timer_expired && !core_done;
                if (core_done || timer_expired)
                    state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_reg        <= '0;
            text_reg       <= '0;
            key_cnt_reg    <= '0;
            text_cnt_reg   <= '0;
            key_loaded_reg <= 1'b0;
            text_full_reg  <= 1'b0;
            en_or_de_reg   <= 1'b0;
            done_reg       <= 1'b0;
            timer_reg      <= '0;
        end else begin
            done_reg <= core_done;
            if (key_accept) begin
                key_reg        <= {key_reg[95:0], bus.word_in};
                key_cnt_reg    <= key_cnt_reg + 2'd1;
                key_loaded_reg <= key_loaded_next;
            end
            if (text_accept) begin
                text_reg      <= {text_reg[95:0], bus.word_in};
                text_cnt_reg  <= text_cnt_reg + 2'd1;
                text_full_reg <= text_full_next;
                if (text_cnt_reg == 2'd3)
                    en_or_de_reg <= bus.en_or_de_in;
            end
            if (state_reg == FIRE)
                timer_reg <= '0;
            else if (state_reg == WAIT)
                timer_reg <= timer_reg + 1'b1;
            // Leaving WAIT frees the text slot; key and output registers are kept.
            if (core_done || timer_expired) begin
                text_full_reg <= 1'b0;
                text_cnt_reg  <= 2'd0;
            end
        end
    end

    assign bus.word_ready_out = word_ready;
    assign bus.key_out        = key_reg;
    assign bus.text_out       = text_reg;
    assign bus.en_or_de_out   = en_or_de_reg;
    assign bus.start_out      = start;
    assign bus.busy_out       = busy;
    assign bus.done_out       = done_reg;
    assign bus.timeout_out    = timeout;
endmodule

// File: tb/tb_aes_word_loader.sv
// Directed cycle-vector bench for aes_word_loader with an 8-cycle timeout.
module tb_aes_word_loader;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    aes_word_loader_if bus ();

    aes_word_loader #(.TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected {ready, start, busy, done, timeout} during a cycle.
    localparam logic [4:0] E_ZERO = 5'b00000;
    localparam logic [4:0] E_IDLE = 5'b10000;
    localparam logic [4:0] E_FIRE = 5'b01100;
    localparam logic [4:0] E_WAIT = 5'b00100;
    localparam logic [4:0] E_DONE = 5'b10010;
    localparam logic [4:0] E_TO   = 5'b00101;

    typedef struct {
        logic        rst;
        logic        valid;
        logic        is_key;
        logic        en;
        logic [31:0] word;
        logic        done;
        logic [4:0]  exp;
    } vec_t;

    vec_t tab[$];

    task automatic add(input logic rst, input logic valid, input logic is_key,
                       input logic en, input logic [31:0] word, input logic done,
                       input logic [4:0] exp);
        vec_t v;
        v.rst = rst; v.valid = valid; v.is_key = is_key; v.en = en;
        v.word = word; v.done = done; v.exp = exp;
        tab.push_back(v);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Applies and empties the vector table; inputs change 1 time unit after
    // the rising edge, outputs are sampled on the falling edge.
    task automatic run_tab(input string tag);
        logic [4:0] act;
        for (int i = 0; i < tab.size(); i++) begin
            reset              = tab[i].rst;
            bus.word_valid_in  = tab[i].valid;
            bus.word_is_key_in = tab[i].is_key;
            bus.en_or_de_in    = tab[i].en;
            bus.word_in        = tab[i].word;
            bus.core_done_in   = tab[i].done;
            @(negedge clk);
            act = {bus.word_ready_out, bus.start_out, bus.busy_out,
                   bus.done_out, bus.timeout_out};
            chk($sformatf("%s[%0d] rdy/start/busy/done/to", tag, i),
                {123'd0, act}, {123'd0, tab[i].exp});
            @(posedge clk);
            #1;
        end
        tab.delete();
        $display("segment %s done, errors so far %0d", tag, errors);
    endtask

    task automatic chk_regs(input string tag, input logic [127:0] key,
                            input logic [127:0] text, input logic en);
        chk({tag, " key_out"},  bus.key_out,  key);
        chk({tag, " text_out"}, bus.text_out, text);
        chk({tag, " en_or_de"}, {127'd0, bus.en_or_de_out}, {127'd0, en});
    endtask

    initial begin
        reset              = 1'b1;
        bus.word_valid_in  = 1'b0;
        bus.word_is_key_in = 1'b0;
        bus.en_or_de_in    = 1'b0;
        bus.word_in        = '0;
        bus.core_done_in   = 1'b0;
        @(posedge clk);
        #1;

        // Reset state.
        add(1, 0, 0, 0, 32'h0, 0, E_ZERO);
        add(1, 1, 1, 0, 32'h0, 0, E_ZERO);
        run_tab("reset");
        chk_regs("reset", 128'h0, 128'h0, 1'b0);

        // Key then text, core completes on the 2nd WAIT cycle.
        add(0, 1, 1, 0, 32'h0,        0, E_IDLE);
        add(0, 1, 1, 0, 32'h0,        0, E_IDLE);
        add(0, 1, 1, 0, 32'h0,        0, E_IDLE);
        add(0, 1, 1, 0, 32'h00003000, 0, E_IDLE);
        add(0, 1, 0, 0, 32'h89bdf4c1, 0, E_IDLE);
        add(0, 1, 0, 0, 32'h3a2aa678, 0, E_IDLE);
        add(0, 1, 0, 0, 32'h96d6b2a0, 0, E_IDLE);
        add(0, 1, 0, 0, 32'hf3e0ff4e, 0, E_IDLE);
        add(0, 0, 0, 0, 32'h0,        0, E_FIRE);
        add(0, 0, 0, 0, 32'h0,        0, E_WAIT);
        add(0, 0, 0, 0, 32'h0,        1, E_WAIT);
        add(0, 0, 0, 0, 32'h0,        0, E_DONE);
        add(0, 0, 0, 0, 32'h0,        0, E_IDLE);
        run_tab("basic");
        chk_regs("basic", 128'h3000,
                 128'h89bdf4c1_3a2aa678_96d6b2a0_f3e0ff4e, 1'b0);

        // Retained key: 4 text words alone fire with en_or_de=1.
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 1, 32'h11111111, 0, E_IDLE);
        add(0, 0, 0, 0, 32'h0, 0, E_FIRE);
        run_tab("retain");
        chk_regs("retain", 128'h3000,
                 128'h11111111_11111111_11111111_11111111, 1'b1);

        // No done: timeout on the 8th WAIT cycle, then LOAD accepts new text.
        for (int i = 0; i < 7; i++)
            add(0, 0, 0, 0, 32'h0, 0, E_WAIT);
        add(0, 0, 0, 0, 32'h0, 0, E_TO);
        add(0, 1, 0, 0, 32'ha0a0a0a0, 0, E_IDLE);
        add(0, 1, 0, 0, 32'hb1b1b1b1, 0, E_IDLE);
        add(0, 1, 0, 0, 32'hc2c2c2c2, 0, E_IDLE);
        add(0, 1, 0, 0, 32'hd3d3d3d3, 0, E_IDLE);
        add(0, 0, 0, 0, 32'h0, 0, E_FIRE);
        run_tab("timeout");

        // Done arriving on the 8th WAIT cycle beats the timeout.
        for (int i = 0; i < 7; i++)
            add(0, 0, 0, 0, 32'h0, 0, E_WAIT);
        add(0, 0, 0, 0, 32'h0, 1, E_WAIT);
        add(0, 0, 0, 0, 32'h0, 0, E_DONE);
        run_tab("done_vs_to");
        chk_regs("done_vs_to", 128'h3000,
                 128'ha0a0a0a0_b1b1b1b1_c2c2c2c2_d3d3d3d3, 1'b0);

        // Reset while in WAIT.
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 0, 32'h55555555, 0, E_IDLE);
        add(0, 0, 0, 0, 32'h0, 0, E_FIRE);
        add(0, 0, 0, 0, 32'h0, 0, E_WAIT);
        add(1, 0, 0, 0, 32'h0, 1, E_WAIT);
        add(1, 0, 0, 0, 32'h0, 1, E_ZERO);
        run_tab("rst_wait");
        chk_regs("rst_wait", 128'h0, 128'h0, 1'b0);

        // Reset after two key words: the partial key is forgotten.
        add(0, 1, 1, 0, 32'hcafef00d, 0, E_IDLE);
        add(0, 1, 1, 0, 32'h12345678, 0, E_IDLE);
        add(1, 1, 1, 0, 32'h9abcdef0, 0, E_ZERO);
        add(1, 0, 0, 0, 32'h0,        0, E_ZERO);
        run_tab("rst_key");
        chk_regs("rst_key", 128'h0, 128'h0, 1'b0);

        // Text alone after reset never fires; further text words stall.
        add(0, 1, 0, 1, 32'h01020304, 0, E_IDLE);
        add(0, 1, 0, 1, 32'h05060708, 0, E_IDLE);
        add(0, 1, 0, 1, 32'h090a0b0c, 0, E_IDLE);
        add(0, 1, 0, 1, 32'h0d0e0f10, 0, E_IDLE);
        for (int i = 0; i < 8; i++)
            add(0, 0, 0, 0, 32'h0, 0, E_ZERO);
        run_tab("text_only");
        chk_regs("text_only", 128'h0,
                 128'h01020304_05060708_090a0b0c_0d0e0f10, 1'b1);

        // Fifth text word held valid while the key arrives.
        add(0, 1, 0, 0, 32'hdeadbeef, 0, E_ZERO);
        add(0, 1, 0, 0, 32'hdeadbeef, 0, E_ZERO);
        add(0, 1, 1, 0, 32'h2b7e1516, 0, E_IDLE);
        add(0, 1, 1, 0, 32'h28aed2a6, 0, E_IDLE);
        add(0, 1, 1, 0, 32'habf71588, 0, E_IDLE);
        add(0, 1, 1, 0, 32'h09cf4f3c, 0, E_IDLE);
        add(0, 1, 0, 0, 32'hdeadbeef, 0, E_FIRE);
        add(0, 1, 0, 0, 32'hdeadbeef, 0, E_WAIT);
        run_tab("text_first");
        chk_regs("text_first", 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
                 128'h01020304_05060708_090a0b0c_0d0e0f10, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
